// File: rtl/core_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : core_io_bridge
// Description : Instruction-bus wrapper around one generated compute core.
//               Exposes TOTAL_INPUTS input registers followed by
//               TOTAL_OUTPUTS output registers in a contiguous address
//               window, sequences the core through a start/done handshake,
//               captures its results, supports bound streaming and raises
//               a level interrupt when a run completes.
// Revision    : 1.0 - initial release
// ============================================================================
module core_io_bridge #(
    parameter int                       INSTRUCTION_WIDTH = 8,
    parameter int                       ADDRESS_WIDTH     = 24,
    parameter int                       VALUE_WIDTH       = 32,
    parameter int                       TOTAL_INPUTS      = 2,
    parameter int                       TOTAL_OUTPUTS     = 1,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS     = '0,
    parameter bit                       AUTO_START        = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [INSTRUCTION_WIDTH-1:0]         instruction_i,
    input  logic [ADDRESS_WIDTH-1:0]             address_i,
    input  logic [VALUE_WIDTH-1:0]               value_i,
    output logic [VALUE_WIDTH-1:0]               result_o,
    output logic                                 result_valid_o,
    output logic [VALUE_WIDTH-1:0]               stream_o,
    output logic                                 stream_valid_o,
    output logic                                 core_interrupt_o,
    output logic [TOTAL_INPUTS*VALUE_WIDTH-1:0]  core_inputs_o,
    output logic                                 core_start_o,
    input  logic [TOTAL_OUTPUTS*VALUE_WIDTH-1:0] core_outputs_i,
    input  logic                                 core_done_i
);

    // Opcode encodings of the instruction bus
    localparam logic [INSTRUCTION_WIDTH-1:0] c_OP_READ       = INSTRUCTION_WIDTH'(1);
    localparam logic [INSTRUCTION_WIDTH-1:0] c_OP_WRITE      = INSTRUCTION_WIDTH'(2);
    localparam logic [INSTRUCTION_WIDTH-1:0] c_OP_STREAM     = INSTRUCTION_WIDTH'(3);
    localparam logic [INSTRUCTION_WIDTH-1:0] c_OP_BIND_READ  = INSTRUCTION_WIDTH'(4);
    localparam logic [INSTRUCTION_WIDTH-1:0] c_OP_BIND_WRITE = INSTRUCTION_WIDTH'(5);
    localparam logic [INSTRUCTION_WIDTH-1:0] c_OP_BIND_IRQ   = INSTRUCTION_WIDTH'(6);

    // Run sequencer states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_START   = 2'd1;
    localparam logic [1:0] c_ST_BUSY    = 2'd2;
    localparam logic [1:0] c_ST_CAPTURE = 2'd3;

    localparam int c_IN_IDX_W  = (TOTAL_INPUTS  > 1) ? $clog2(TOTAL_INPUTS)  : 1;
    localparam int c_OUT_IDX_W = (TOTAL_OUTPUTS > 1) ? $clog2(TOTAL_OUTPUTS) : 1;
    localparam int c_AW1       = ADDRESS_WIDTH + 1;

    // One extra address bit so that window arithmetic never wraps
    localparam logic [ADDRESS_WIDTH:0]  c_IN_BASE  = {1'b0, START_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0]  c_OUT_BASE = c_IN_BASE + c_AW1'(TOTAL_INPUTS);
    localparam logic [c_IN_IDX_W-1:0]   c_LAST_IN  = c_IN_IDX_W'(TOTAL_INPUTS - 1);

    logic [VALUE_WIDTH-1:0]              r_in_regs  [TOTAL_INPUTS];
    logic [VALUE_WIDTH-1:0]              r_out_regs [TOTAL_OUTPUTS];
    logic [TOTAL_INPUTS*VALUE_WIDTH-1:0] r_snapshot;
    logic [VALUE_WIDTH-1:0]              r_result;
    logic                                r_result_valid;
    logic [VALUE_WIDTH-1:0]              r_stream;
    logic                                r_stream_valid;
    logic                                r_irq;
    logic                                r_irq_en;
    logic                                r_wbind;
    logic [c_IN_IDX_W-1:0]               r_widx;
    logic                                r_rbind;
    logic [c_OUT_IDX_W-1:0]              r_ridx;
    logic                                r_pending;
    logic [1:0]                          r_state;

    logic [ADDRESS_WIDTH:0]              w_addr;
    logic [ADDRESS_WIDTH:0]              w_in_off;
    logic [ADDRESS_WIDTH:0]              w_out_off;
    logic                                w_in_hit;
    logic                                w_out_hit;
    logic [c_IN_IDX_W-1:0]               w_in_idx;
    logic [c_OUT_IDX_W-1:0]              w_out_idx;
    logic                                w_is_read;
    logic                                w_is_write;
    logic                                w_is_stream;
    logic                                w_is_bind_rd;
    logic                                w_is_bind_wr;
    logic                                w_is_bind_irq;
    logic                                w_run_req;
    logic                                w_irq_set;
    logic                                w_irq_clear;

    // Address decode: an address below a range base wraps to a huge offset
    // in the widened arithmetic, so one unsigned compare covers both bounds.
    assign w_addr    = {1'b0, address_i};
    assign w_in_off  = w_addr - c_IN_BASE;
    assign w_out_off = w_addr - c_OUT_BASE;
    assign w_in_hit  = (w_in_off  < c_AW1'(TOTAL_INPUTS));
    assign w_out_hit = (w_out_off < c_AW1'(TOTAL_OUTPUTS));
    assign w_in_idx  = c_IN_IDX_W'(w_in_off);
    assign w_out_idx = c_OUT_IDX_W'(w_out_off);

    assign w_is_read     = (instruction_i == c_OP_READ);
    assign w_is_write    = (instruction_i == c_OP_WRITE);
    assign w_is_stream   = (instruction_i == c_OP_STREAM);
    assign w_is_bind_rd  = (instruction_i == c_OP_BIND_READ);
    assign w_is_bind_wr  = (instruction_i == c_OP_BIND_WRITE);
    assign w_is_bind_irq = (instruction_i == c_OP_BIND_IRQ);

    // A run is requested by completing the input set or by any streamed input
    assign w_run_req = AUTO_START &&
                       ((w_is_write && w_in_hit && (w_in_idx == c_LAST_IN)) ||
                        (w_is_stream && r_wbind));

    // Completion sets the interrupt; reading an output or unbinding clears it
    assign w_irq_set   = (r_state == c_ST_CAPTURE) && r_irq_en;
    assign w_irq_clear = (w_is_read && w_out_hit) ||
                         (w_is_bind_irq && !(w_in_hit || w_out_hit));

    // Input register file, written by bus WRITE or bound STREAM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < TOTAL_INPUTS; k++) begin
                r_in_regs[k] <= '0;
            end
        end else if (w_is_write && w_in_hit) begin
            r_in_regs[w_in_idx] <= value_i;
        end else if (w_is_stream && r_wbind) begin
            r_in_regs[r_widx] <= value_i;
        end
    end

    // Output register file, loaded from the core once per completed run
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < TOTAL_OUTPUTS; k++) begin
                r_out_regs[k] <= '0;
            end
        end else if (r_state == c_ST_CAPTURE) begin
            for (int k = 0; k < TOTAL_OUTPUTS; k++) begin
                r_out_regs[k] <= core_outputs_i[k*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end
    end

    // READ response path; output registers return their pre-capture value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_is_read && w_in_hit) begin
                r_result       <= r_in_regs[w_in_idx];
                r_result_valid <= 1'b1;
            end else if (w_is_read && w_out_hit) begin
                r_result       <= r_out_regs[w_out_idx];
                r_result_valid <= 1'b1;
            end
        end
    end

    // STREAM read path through the bound output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stream       <= '0;
            r_stream_valid <= 1'b0;
        end else begin
            r_stream_valid <= 1'b0;
            if (w_is_stream && r_rbind) begin
                r_stream       <= r_out_regs[r_ridx];
                r_stream_valid <= 1'b1;
            end
        end
    end

    // Stream bindings and interrupt enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wbind  <= 1'b0;
            r_widx   <= '0;
            r_rbind  <= 1'b0;
            r_ridx   <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_is_bind_wr) begin
                if (w_in_hit) begin
                    r_wbind <= 1'b1;
                    r_widx  <= w_in_idx;
                end else if (!w_out_hit) begin
                    r_wbind <= 1'b0;
                end
            end
            if (w_is_bind_rd) begin
                if (w_out_hit) begin
                    r_rbind <= 1'b1;
                    r_ridx  <= w_out_idx;
                end else if (!w_in_hit) begin
                    r_rbind <= 1'b0;
                end
            end
            if (w_is_bind_irq) begin
                r_irq_en <= w_in_hit || w_out_hit;
            end
        end
    end

    // Interrupt level; a completing run wins over a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (w_irq_clear) begin
            r_irq <= 1'b0;
        end
    end

    // Pending request flag; a request arriving while one is consumed survives
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_run_req || (r_pending && (r_state != c_ST_IDLE));
        end
    end

    // Run sequencer with input snapshot taken when a run is launched
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_snapshot <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_pending) begin
                        r_state <= c_ST_START;
                        for (int k = 0; k < TOTAL_INPUTS; k++) begin
                            r_snapshot[k*VALUE_WIDTH +: VALUE_WIDTH] <= r_in_regs[k];
                        end
                    end
                end
                c_ST_START: begin
                    r_state <= c_ST_BUSY;
                end
                c_ST_BUSY: begin
                    if (core_done_i) begin
                        r_state <= c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign result_o         = r_result;
    assign result_valid_o   = r_result_valid;
    assign stream_o         = r_stream;
    assign stream_valid_o   = r_stream_valid;
    assign core_interrupt_o = r_irq;
    assign core_inputs_o    = r_snapshot;
    assign core_start_o     = (r_state == c_ST_START);

endmodule
`default_nettype wire

// File: tb/tb_core_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_io_bridge
// Description : Self-checking bench for core_io_bridge (2 inputs, 2 outputs,
//               window at 0x10). A transaction-level model predicts every
//               output each cycle; a small core stub answers start pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_io_bridge;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_RD  = 8'h01;
    localparam logic [7:0] OP_WR  = 8'h02;
    localparam logic [7:0] OP_ST  = 8'h03;
    localparam logic [7:0] OP_BR  = 8'h04;
    localparam logic [7:0] OP_BW  = 8'h05;
    localparam logic [7:0] OP_BI  = 8'h06;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  instruction_i = '0;
    logic [23:0] address_i = '0;
    logic [31:0] value_i = '0;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic [31:0] stream_o;
    logic        stream_valid_o;
    logic        core_interrupt_o;
    logic [63:0] core_inputs_o;
    logic        core_start_o;
    logic [63:0] core_outputs_i = '0;
    logic        core_done_i = 1'b0;

    core_io_bridge #(
        .INSTRUCTION_WIDTH (8),
        .ADDRESS_WIDTH     (24),
        .VALUE_WIDTH       (32),
        .TOTAL_INPUTS      (2),
        .TOTAL_OUTPUTS     (2),
        .START_ADDRESS     (24'h10),
        .AUTO_START        (1'b1)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .instruction_i    (instruction_i),
        .address_i        (address_i),
        .value_i          (value_i),
        .result_o         (result_o),
        .result_valid_o   (result_valid_o),
        .stream_o         (stream_o),
        .stream_valid_o   (stream_valid_o),
        .core_interrupt_o (core_interrupt_o),
        .core_inputs_o    (core_inputs_o),
        .core_start_o     (core_start_o),
        .core_outputs_i   (core_outputs_i),
        .core_done_i      (core_done_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int lat = 3;

    // ---------------- behavioural model state ----------------
    logic [31:0] m_in [2];
    logic [31:0] m_out [2];
    logic [31:0] m_snap [2];
    logic [31:0] m_res = '0, m_stream = '0;
    bit m_rv = 0, m_sv = 0, m_irq = 0, m_irq_en = 0;
    bit m_wbind = 0, m_rbind = 0;
    int m_widx = 0, m_ridx = 0;
    bit m_pend = 0, m_in_run = 0;
    int m_start_at = -1, m_cap_at = -1;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in[k] = '0; m_out[k] = '0; m_snap[k] = '0;
        end
        m_res = '0; m_stream = '0; m_rv = 0; m_sv = 0; m_irq = 0; m_irq_en = 0;
        m_wbind = 0; m_rbind = 0; m_widx = 0; m_ridx = 0;
        m_pend = 0; m_in_run = 0; m_start_at = -1; m_cap_at = -1;
    endtask

    // Applies the bus operation and run progress of the cycle that just ended
    task automatic model_step();
        int c = cyc;
        bit in_hit, out_hit, do_cap, irq_set, irq_clr;
        int ii, oi;
        in_hit  = (address_i == 24'h10) || (address_i == 24'h11);
        out_hit = (address_i == 24'h12) || (address_i == 24'h13);
        ii = (address_i == 24'h11) ? 1 : 0;
        oi = (address_i == 24'h13) ? 1 : 0;
        do_cap = 0; irq_clr = 0;
        if (!m_in_run) begin
            if (m_pend) begin
                m_snap[0] = m_in[0]; m_snap[1] = m_in[1];
                m_pend = 0; m_in_run = 1; m_start_at = c + 1;
            end
        end else if (m_cap_at == c) begin
            do_cap = 1; m_in_run = 0; m_cap_at = -1;
        end else if (m_cap_at < 0 && c > m_start_at && core_done_i) begin
            m_cap_at = c + 1;
        end
        irq_set = do_cap && m_irq_en;
        m_rv = 0; m_sv = 0;
        case (instruction_i)
            OP_RD: begin
                if (in_hit) begin m_res = m_in[ii]; m_rv = 1; end
                else if (out_hit) begin m_res = m_out[oi]; m_rv = 1; irq_clr = 1; end
            end
            OP_WR: if (in_hit) begin
                m_in[ii] = value_i;
                if (ii == 1) m_pend = 1;
            end
            OP_ST: begin
                if (m_wbind) begin m_in[m_widx] = value_i; m_pend = 1; end
                if (m_rbind) begin m_stream = m_out[m_ridx]; m_sv = 1; end
            end
            OP_BW: if (in_hit) begin m_wbind = 1; m_widx = ii; end
                   else if (!out_hit) m_wbind = 0;
            OP_BR: if (out_hit) begin m_rbind = 1; m_ridx = oi; end
                   else if (!in_hit) m_rbind = 0;
            OP_BI: if (in_hit || out_hit) m_irq_en = 1;
                   else begin m_irq_en = 0; irq_clr = 1; end
            default: ;
        endcase
        if (do_cap) begin
            m_out[0] = core_outputs_i[31:0];
            m_out[1] = core_outputs_i[63:32];
        end
        if (irq_set) m_irq = 1;
        else if (irq_clr) m_irq = 0;
        cyc = c + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) model_reset();
            else model_step();
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                check("result_valid", 64'(result_valid_o), 64'(m_rv));
                check("result", 64'(result_o), 64'(m_res));
                check("stream_valid", 64'(stream_valid_o), 64'(m_sv));
                check("stream", 64'(stream_o), 64'(m_stream));
                check("interrupt", 64'(core_interrupt_o), 64'(m_irq));
                check("core_start", 64'(core_start_o), 64'(cyc == m_start_at));
                check("core_inputs", core_inputs_o, {m_snap[1], m_snap[0]});
            end
        end
    end

    // Core stub: word0 = a+b, word1 = a*b, done pulse lat cycles after start
    int cd_due = -1;
    logic [63:0] cd_vals = '0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (core_start_o === 1'b1) begin
                cd_due  = cyc + lat;
                cd_vals = {core_inputs_o[31:0] * core_inputs_o[63:32],
                           core_inputs_o[31:0] + core_inputs_o[63:32]};
            end
            #1;
            if (cyc == cd_due) begin
                core_done_i    = 1'b1;
                core_outputs_i = cd_vals;
            end else begin
                core_done_i = 1'b0;
            end
        end
    end

    // Drive one bus cycle; returns at the negedge where its response is visible
    task automatic drive(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        #1;
        instruction_i = op; address_i = a; value_i = v;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(OP_NOP, 24'h0, 32'h0);
    endtask

    task automatic do_reset();
        #1;
        rst_i = 1'b1; instruction_i = OP_NOP;
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    int starts;

    initial begin
        repeat (3) @(negedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_en = 1'b1;

        // Reset state: reads of three addresses return 0 with a strobe
        check("lit_reset_irq", 64'(core_interrupt_o), 64'd0);
        drive(OP_RD, 24'h10, 0);
        check("lit_rd0_valid", 64'(result_valid_o), 64'd1);
        check("lit_rd0_val", 64'(result_o), 64'd0);
        drive(OP_RD, 24'h11, 0);
        check("lit_rd1_valid", 64'(result_valid_o), 64'd1);
        drive(OP_RD, 24'h12, 0);
        check("lit_rd2_valid", 64'(result_valid_o), 64'd1);
        check("lit_rd2_val", 64'(result_o), 64'd0);

        // Basic run: 5,7 -> {12,35}, start two cycles after the request
        drive(OP_WR, 24'h10, 5);
        drive(OP_WR, 24'h11, 7);
        check("lit_start_early", 64'(core_start_o), 64'd0);
        drive(OP_NOP, 0, 0);
        check("lit_start", 64'(core_start_o), 64'd1);
        check("lit_snapshot", core_inputs_o, {32'd7, 32'd5});
        drive(OP_NOP, 0, 0);
        check("lit_start_once", 64'(core_start_o), 64'd0);
        idle(6);
        drive(OP_RD, 24'h12, 0);
        check("lit_out0", 64'(result_o), 64'd12);
        drive(OP_RD, 24'h13, 0);
        check("lit_out1", 64'(result_o), 64'd35);

        // Interrupt: enable, run 5,3 -> {8,15}, clear by reading an output
        drive(OP_BI, 24'h10, 0);
        drive(OP_WR, 24'h11, 3);
        idle(8);
        check("lit_irq_set", 64'(core_interrupt_o), 64'd1);
        drive(OP_RD, 24'h12, 0);
        check("lit_irq_clr", 64'(core_interrupt_o), 64'd0);
        check("lit_out0_b", 64'(result_o), 64'd8);
        drive(OP_BI, 24'h99, 0);
        drive(OP_WR, 24'h11, 3);
        idle(9);
        check("lit_irq_disabled", 64'(core_interrupt_o), 64'd0);

        // Streaming: four back-to-back streamed writes coalesce into two runs
        drive(OP_BW, 24'h11, 0);
        drive(OP_BR, 24'h13, 0);
        starts = 0;
        drive(OP_ST, 24'h0, 9);
        check("lit_stream_valid", 64'(stream_valid_o), 64'd1);
        check("lit_stream_val", 64'(stream_o), 64'd15);
        if (core_start_o) starts++;
        for (int i = 0; i < 3; i++) begin
            drive(OP_ST, 24'h0, 9);
            if (core_start_o) starts++;
        end
        for (int i = 0; i < 16; i++) begin
            drive(OP_NOP, 0, 0);
            if (core_start_o) starts++;
        end
        check("lit_stream_runs", 64'(starts), 64'd2);

        // Unbound stream read and ignored write to an output register
        drive(OP_BR, 24'h99, 0);
        drive(OP_ST, 24'h0, 9);
        check("lit_stream_unbound", 64'(stream_valid_o), 64'd0);
        idle(10);
        drive(OP_WR, 24'h12, 32'hFF);
        drive(OP_RD, 24'h12, 0);
        check("lit_out_readonly", 64'(result_o), 64'd14);

        // Reset while the core is busy; the late done must be ignored
        drive(OP_BI, 24'h10, 0);
        drive(OP_WR, 24'h11, 4);
        idle(2);
        do_reset();
        idle(6);
        check("lit_rst_irq", 64'(core_interrupt_o), 64'd0);
        drive(OP_RD, 24'h12, 0);
        check("lit_rst_out0", 64'(result_o), 64'd0);
        drive(OP_RD, 24'h13, 0);
        check("lit_rst_out1", 64'(result_o), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [7:0]  op;
            logic [23:0] a;
            logic [31:0] v;
            int r;
            lat = $urandom_range(1, 5);
            r = $urandom_range(0, 9);
            case (r)
                0, 9: op = OP_RD;
                1: op = OP_WR;
                2, 3: op = OP_ST;
                4: op = OP_BW;
                5: op = OP_BR;
                6: op = OP_BI;
                7: op = OP_NOP;
                default: op = 8'hAB;
            endcase
            r = $urandom_range(0, 9);
            if (r <= 5) a = 24'h0F + 24'(r);
            else if (r <= 7) a = 24'h10 + 24'($urandom_range(0, 3));
            else if (r == 8) a = 24'h99;
            else a = 24'($urandom);
            v = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
            if ($urandom_range(0, 199) == 0) do_reset();
            else drive(op, a, v);
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
